weight_load_ctrl: RTL and testbench
===================================

Name: weight_load_ctrl

Overview:
- Sequencer in front of weight_loader.
- On a start command it fetches packed kernel weights from a synchronous-read weight memory and streams them as AXI-Stream beats into the loader.
- Pads unused beats with zeros so the loader always receives its fixed beat count.
- Waits for the loader to finish, hands the weights to the convolution datapath, and repeats for NUM_KERNELS kernels.

Parameters:
- MAX_KERNEL, 4, largest kernel side supported by weight_loader.
- WEIGHT_WIDTH, 8, bits per weight.
- BUS_WIDTH, 32, AXI-Stream data width.
- ADDR_WIDTH, 10, weight memory word address width.
- CNT_WIDTH, 8, width of the kernel count.
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only).
- Derived: TOTAL_BEATS = MAX_KERNEL*MAX_KERNEL*WEIGHT_WIDTH/BUS_WIDTH, which is 4 at the defaults.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- cfg_kernel_size  in  3  kernel side K, valid range 1..MAX_KERNEL; latched on start.
- cfg_base_addr  in  ADDR_WIDTH  first memory word; latched on start.
- cfg_num_kernels  in  CNT_WIDTH  number of kernels N, must be >=1; latched on start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  BUS_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- m_axis_tdata  out  BUS_WIDTH  beat to weight_loader.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  loader ready.
- loader_loading  in  1  weight_loader "loading" status.
- weights_ready  out  1  current kernel is loaded; level signal.
- weights_consumed  in  1  datapath ack pulse; releases the current kernel.
- kernel_idx  out  CNT_WIDTH  index of the kernel currently being loaded or held.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last kernel is consumed.
- err_cfg  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: every output is 0, m_axis_tdata is 0, state is IDLE.
  - Reset mid-operation aborts immediately. tvalid drops asynchronously; this is the only permitted tvalid drop without a handshake.
- USED_BEATS = ceil(K*K*WEIGHT_WIDTH/BUS_WIDTH), giving K=1:1, K=2:1, K=3:3, K=4:4.
  - Beats USED_BEATS..TOTAL_BEATS-1 are zero pads and are not fetched from memory.
- Config check on start in IDLE:
  - K==0, K>MAX_KERNEL or N==0: pulse err_cfg, stay IDLE, no other output changes.
  - start outside IDLE is ignored.
- States:
  - IDLE: on a valid start, latch the config, set addr=base, beat=0, kernel_idx=0, go to WAIT_LOAD.
  - WAIT_LOAD: wait for loader_loading==1, then go to FETCH (or PAD if USED_BEATS==0 remain).
  - FETCH: mem_rd_en=1 and mem_addr=addr for one cycle; addr increments (wraps modulo 2^ADDR_WIDTH); go to CAPTURE.
  - CAPTURE: register mem_rdata into m_axis_tdata, set tvalid=1, go to SEND.
  - PAD: tdata=0, tvalid=1, go to SEND.
  - SEND: hold tdata/tvalid stable until tready. On handshake:
    - tvalid=0 next cycle, beat++.
    - If beat < USED_BEATS, go to FETCH.
    - Else if beat < TOTAL_BEATS, go to PAD.
    - Else go to WAIT_DONE.
  - WAIT_DONE: wait for loader_loading==0, then set weights_ready=1 and go to HOLD.
  - HOLD: on weights_consumed:
    - weights_ready=0.
    - If kernel_idx==N-1: pulse done, go to IDLE.
    - Else kernel_idx++, beat=0, go to WAIT_LOAD. Address continues contiguously.
- Latency: the first tvalid rises 2 cycles after FETCH entry.
  - Fetched beats: at least 3 cycles per beat. Pad beats: at least 2 cycles per beat.
- weights_consumed outside HOLD is ignored.
- A tready that is already high when tvalid rises completes the handshake in that same cycle.
- Memory words are packed MSB-first, matching the loader's ordering: word 0 holds the first weights in its high bits.

Optional Feature:
- Macro: WEIGHT_LOAD_CTRL_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, reset 0) and a watchdog counter.
  - The counter clears on every state change and counts cycles spent in WAIT_LOAD, SEND or WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: tvalid=0, weights_ready=0, err_timeout pulses for 1 cycle, state goes to IDLE, and done does not pulse.
- Undefined: no err_timeout port and no counter; the controller waits indefinitely.

Test Plan:
- K=3, N=1, base=0x010, memory words 0x010..0x012 = A1B2C3D4, 11223344, 55667788, tready always 1, loader model loading:
  - Beats are A1B2C3D4, 11223344, 55667788, 00000000.
  - mem_addr visits 0x010..0x012 only.
  - weights_ready rises after loading falls; done pulses 1 cycle after weights_consumed.
- K=2, N=3, base=0x3FF:
  - Addresses are 0x3FF, 0x000, 0x001 (wrap-around); each kernel sends 1 data beat and 3 zero beats.
  - kernel_idx steps 0,1,2; exactly one done pulse.
- Backpressure:
  - tready low for 5 cycles on beat 1 -> tdata and tvalid held stable; no beat lost or duplicated.
  - tready already high at tvalid rise -> the handshake completes in that cycle.
- Bad config: start with K=5, K=0, or N=0 -> err_cfg pulses, busy stays 0, no mem_rd_en and no tvalid.
- rstn asserted in SEND with K=4, N=2:
  - All outputs are 0 immediately.
  - A fresh start after release begins again at beat 0 and kernel_idx 0.
- With WEIGHT_LOAD_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, loader_loading held 0 after start:
  - err_timeout pulses at cycle 16 of WAIT_LOAD, and busy returns to 0.
  - Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: fetches packed kernel weights from a sync-read memory and streams
// them to weight_loader over AXI-Stream. Optional watchdog: define WEIGHT_LOAD_CTRL_TIMEOUT_EN.
module weight_load_ctrl #(
    parameter int MAX_KERNEL     = 4,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [2:0]            cfg_kernel_size,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_num_kernels,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic [BUS_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  loader_loading,
    output logic                  weights_ready,
    input  logic                  weights_consumed,
    output logic [CNT_WIDTH-1:0]  kernel_idx,
    output logic                  busy,
    output logic                  done,
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
    output logic                  err_timeout,
`endif
    output logic                  err_cfg
);

    // state     | meaning
    // IDLE      | waiting for a valid start
    // WAIT_LOAD | waiting for the loader to report loading
    // FETCH     | memory read strobe for the current beat
    // CAPTURE   | read data lands in the output beat register
    // PAD       | zero beat loaded into the output register
    // SEND      | beat presented until handshake
    // WAIT_DONE | waiting for the loader to finish
    // HOLD      | weights ready, waiting for the datapath ack
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_FETCH, S_CAPTURE, S_PAD, S_SEND, S_WAIT_DONE, S_HOLD
    } state_t;

    localparam int TOTAL_BEATS = MAX_KERNEL * MAX_KERNEL * WEIGHT_WIDTH / BUS_WIDTH;
    localparam int BEAT_W      = $clog2(TOTAL_BEATS + 1);
    localparam logic [BEAT_W-1:0] TOTAL_B = BEAT_W'(TOTAL_BEATS);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d, used_q, used_d, beat_inc;
    logic [CNT_WIDTH-1:0]    kidx_q, kidx_d, num_q, num_d;
    logic [BUS_WIDTH-1:0]    tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d, ready_q, ready_d;
    logic                    done_q, done_d, err_cfg_q, err_cfg_d;
    logic                    cfg_ok;
    logic [15:0]             used_calc;

`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_to_q, err_to_d;
    assign err_timeout = err_to_q;
`endif

    assign beat_inc = beat_q + BEAT_W'(1);
    assign cfg_ok   = (cfg_kernel_size != 3'd0) && (32'(cfg_kernel_size) <= MAX_KERNEL)
                      && (cfg_num_kernels != '0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        used_d    = used_q;
        kidx_d    = kidx_q;
        num_d     = num_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_cfg_d = 1'b0;
        // Beats actually carrying weights: ceil(K*K*WEIGHT_WIDTH / BUS_WIDTH)
        used_calc = (16'(cfg_kernel_size) * 16'(cfg_kernel_size) * 16'(WEIGHT_WIDTH)
                     + 16'(BUS_WIDTH - 1)) / 16'(BUS_WIDTH);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        used_d  = BEAT_W'(used_calc);
                        num_d   = cfg_num_kernels;
                        addr_d  = cfg_base_addr;
                        beat_d  = '0;
                        kidx_d  = '0;
                        state_d = S_WAIT_LOAD;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (loader_loading) state_d = (beat_q < used_q) ? S_FETCH : S_PAD;
            end
            S_FETCH: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                tdata_d  = mem_rdata;
                tvalid_d = 1'b1;
                state_d  = S_SEND;
            end
            S_PAD: begin
                tdata_d  = '0;
                tvalid_d = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    beat_d   = beat_inc;
                    if (beat_inc < used_q)       state_d = S_FETCH;
                    else if (beat_inc < TOTAL_B) state_d = S_PAD;
                    else                         state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!loader_loading) begin
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (weights_consumed) begin
                    ready_d = 1'b0;
                    if (kidx_q == num_q - CNT_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        kidx_d  = kidx_q + CNT_WIDTH'(1);
                        beat_d  = '0;
                        state_d = S_WAIT_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
        wd_d     = '0;
        err_to_d = 1'b0;
        // Only waiting states that stay put accumulate; any transition restarts the watchdog
        if ((state_d == state_q) &&
            (state_q == S_WAIT_LOAD || state_q == S_SEND || state_q == S_WAIT_DONE)) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                wd_d     = '0;
                err_to_d = 1'b1;
                tvalid_d = 1'b0;
                ready_d  = 1'b0;
                state_d  = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            beat_q    <= '0;
            used_q    <= '0;
            kidx_q    <= '0;
            num_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_cfg_q <= 1'b0;
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
            wd_q      <= '0;
            err_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            used_q    <= used_d;
            kidx_q    <= kidx_d;
            num_q     <= num_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_cfg_q <= err_cfg_d;
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
            wd_q      <= wd_d;
            err_to_q  <= err_to_d;
`endif
        end
    end

    assign mem_rd_en     = (state_q == S_FETCH);
    assign mem_addr      = mem_rd_en ? addr_q : '0;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign weights_ready = ready_q;
    assign kernel_idx    = kidx_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign err_cfg       = err_cfg_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Randomized bench for weight_load_ctrl: expected beat/address streams come from a
// memory image plus the packing rule, checked by one negedge compare process.
module tb_weight_load_ctrl;

    localparam int AW = 10, BW = 32, CW = 8, TOTAL = 4;

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [2:0]    cfg_k = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [CW-1:0] cfg_n = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rdata = '0;
    logic [BW-1:0] tdata;
    logic          tvalid, tready = 1'b0;
    logic          loading = 1'b0, consumed = 1'b0;
    logic          weights_ready, busy, done, err_cfg;
    logic [CW-1:0] kernel_idx;
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
    logic          err_timeout;
`endif

    weight_load_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_kernel_size(cfg_k), .cfg_base_addr(cfg_base), .cfg_num_kernels(cfg_n),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .loader_loading(loading), .weights_ready(weights_ready),
        .weights_consumed(consumed), .kernel_idx(kernel_idx),
        .busy(busy), .done(done),
`ifdef WEIGHT_LOAD_CTRL_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] mem [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_checks = 0, n_errors = 0;
    logic [BW-1:0] exp_beats[$], got_beats[$];
    int            exp_kidx[$], exp_addrs[$], got_addrs[$];
    int hs_total = 0, rd_cnt = 0, tv_cnt = 0, done_cnt = 0, errcfg_cnt = 0;
    int rd_mode = 0, job_id = 0, last_job = 0, stall = 0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int used_beats(input int k);
        return (k * k * 8 + BW - 1) / BW;
    endfunction

    task automatic build_expected(input int k, input int base, input int n);
        int a, u;
        exp_beats.delete(); exp_addrs.delete(); exp_kidx.delete();
        u = used_beats(k);
        a = base;
        for (int kk = 0; kk < n; kk++)
            for (int b = 0; b < TOTAL; b++) begin
                if (b < u) begin
                    exp_beats.push_back(mem[a % 1024]);
                    exp_addrs.push_back(a % 1024);
                    a++;
                end else begin
                    exp_beats.push_back('0);
                end
                exp_kidx.push_back(kk);
            end
    endtask

    // Compare process: beat stream, addresses, AXI-S hold/drop rules, done timing.
    logic          prev_stall = 1'b0, prev_hs = 1'b0, prev_cons = 1'b0;
    logic [BW-1:0] held = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0; prev_hs = 1'b0; prev_cons = 1'b0;
        end else begin
            if (prev_stall) chk(tvalid && tdata == held, "hold_stable", {tvalid, tdata}, {1'b1, held});
            if (prev_hs) chk(!tvalid, "tvalid_drop", tvalid, 0);
            if (tvalid && tready) begin
                if (exp_beats.size() == 0) chk(0, "extra_beat", tdata, 0);
                else begin
                    logic [BW-1:0] e; int ek;
                    e = exp_beats.pop_front(); ek = exp_kidx.pop_front();
                    chk(tdata == e, "beat_data", tdata, e);
                    chk(int'(kernel_idx) == ek, "beat_kidx", kernel_idx, ek);
                end
                got_beats.push_back(tdata);
                hs_total++;
            end
            if (mem_rd_en) begin
                if (exp_addrs.size() == 0) chk(0, "extra_read", mem_addr, 0);
                else begin
                    int ea;
                    ea = exp_addrs.pop_front();
                    chk(int'(mem_addr) == ea, "mem_addr", mem_addr, ea);
                end
                got_addrs.push_back(int'(mem_addr));
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk(prev_cons, "done_after_consumed", prev_cons, 1);
            end
            if (err_cfg) errcfg_cnt++;
            if (tvalid) tv_cnt++;
            prev_stall = tvalid && !tready;
            prev_hs    = tvalid && tready;
            held       = tdata;
            prev_cons  = consumed;
        end
    end

    // Loader ready: 0 always-ready, 1 random, 2 stall 5 cycles on beat 1, 3 never ready.
    always @(posedge clk) begin
        #1;
        if (last_job != job_id) begin last_job = job_id; stall = 0; end
        case (rd_mode)
            0: tready = 1'b1;
            1: tready = 1'($urandom_range(0, 1));
            2: if (tvalid && (hs_total % TOTAL) == 1 && stall < 5) begin tready = 1'b0; stall++; end
               else tready = 1'b1;
            default: tready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int k, input int base, input int n, input int mode);
        int hs0, d0, budget;
        build_expected(k, base, n);
        hs0 = hs_total; d0 = done_cnt;
        rd_mode = mode; job_id++;
        cfg_k = 3'(k); cfg_base = AW'(base); cfg_n = CW'(n);
        start = 1'b1; tick; start = 1'b0;
        chk(busy, "busy_after_start", busy, 1);
        for (int kk = 0; kk < n; kk++) begin
            repeat ($urandom_range(0, 3)) tick;
            loading = 1'b1;
            budget = 0;
            while (hs_total < hs0 + (kk + 1) * TOTAL && budget < 300) begin tick; budget++; end
            chk(budget < 300, "beats_received", hs_total - hs0, (kk + 1) * TOTAL);
            chk(!weights_ready, "ready_while_loading", weights_ready, 0);
            repeat ($urandom_range(0, 3)) tick;
            loading = 1'b0;
            budget = 0;
            while (!weights_ready && budget < 5) begin tick; budget++; end
            chk(budget == 1, "ready_latency", budget, 1);
            chk(int'(kernel_idx) == kk, "kernel_idx_hold", kernel_idx, kk);
            repeat ($urandom_range(0, 3)) tick;
            consumed = 1'b1; tick; consumed = 1'b0;
            chk(!weights_ready, "ready_release", weights_ready, 0);
        end
        tick; tick;
        chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
        chk(!done, "done_pulse_width", done, 0);
        chk(!busy, "busy_end", busy, 0);
        chk(exp_beats.size() == 0, "beats_missing", exp_beats.size(), 0);
        chk(exp_addrs.size() == 0, "reads_missing", exp_addrs.size(), 0);
    endtask

    task automatic bad_start(input int k, input int n);
        int e0, r0, t0;
        e0 = errcfg_cnt; r0 = rd_cnt; t0 = tv_cnt;
        cfg_k = 3'(k); cfg_n = CW'(n); cfg_base = AW'(5);
        start = 1'b1; tick; start = 1'b0;
        chk(!busy, "bad_busy", busy, 0);
        repeat (3) tick;
        chk(errcfg_cnt - e0 == 1, "err_cfg_pulse", errcfg_cnt - e0, 1);
        chk(rd_cnt == r0 && tv_cnt == t0, "bad_no_activity", (rd_cnt - r0) + (tv_cnt - t0), 0);
        chk(!busy, "bad_busy_after", busy, 0);
    endtask

    initial begin
        int g0, a0, budget, r0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[16] = 32'hA1B2C3D4; mem[17] = 32'h11223344; mem[18] = 32'h55667788;

        #1;
        chk({tvalid, busy, mem_rd_en, done, err_cfg, weights_ready} == 6'b0, "reset_flags",
            {tvalid, busy, mem_rd_en, done, err_cfg, weights_ready}, 0);
        chk(tdata == '0 && kernel_idx == '0 && mem_addr == '0, "reset_data", tdata, 0);
        repeat (3) tick;
        rstn = 1'b1;
        tick;

        g0 = got_beats.size(); a0 = got_addrs.size();
        run_job(3, 'h010, 1, 0);
        chk(got_beats[g0] == 32'hA1B2C3D4, "k3_beat0", got_beats[g0], 32'hA1B2C3D4);
        chk(got_beats[g0+1] == 32'h11223344, "k3_beat1", got_beats[g0+1], 32'h11223344);
        chk(got_beats[g0+2] == 32'h55667788, "k3_beat2", got_beats[g0+2], 32'h55667788);
        chk(got_beats[g0+3] == 32'h0, "k3_pad", got_beats[g0+3], 0);
        chk(got_addrs.size() - a0 == 3 && got_addrs[a0] == 'h10 && got_addrs[a0+2] == 'h12,
            "k3_addrs", got_addrs[a0+2], 'h12);

        g0 = got_beats.size(); a0 = got_addrs.size();
        run_job(2, 'h3FF, 3, 0);
        chk(got_addrs.size() - a0 == 3, "wrap_reads", got_addrs.size() - a0, 3);
        chk(got_addrs[a0] == 'h3FF && got_addrs[a0+1] == 0 && got_addrs[a0+2] == 1, "wrap_addrs",
            got_addrs[a0+1], 0);
        chk(got_beats[g0+5] == 0 && got_beats[g0+4] == mem[0], "k2_second_kernel", got_beats[g0+4], mem[0]);

        run_job(4, 'h100, 1, 2);
        chk(stall == 5, "stall_cycles", stall, 5);

        bad_start(5, 1);
        bad_start(0, 1);
        bad_start(3, 0);
        bad_start(7, 2);

        // Asynchronous reset while a beat sits in SEND.
        rd_mode = 3; job_id++;
        build_expected(4, 'h200, 2);
        cfg_k = 3'd4; cfg_base = AW'('h200); cfg_n = CW'(2);
        start = 1'b1; tick; start = 1'b0;
        loading = 1'b1;
        budget = 0;
        while (!tvalid && budget < 20) begin tick; budget++; end
        chk(tvalid, "reach_send", tvalid, 1);
        @(negedge clk); #2;
        rstn = 1'b0; #1;
        chk(!tvalid && tdata == '0, "rst_tvalid", tvalid, 0);
        chk({busy, mem_rd_en, weights_ready, done, err_cfg} == 5'b0 && kernel_idx == '0,
            "rst_outputs", {busy, mem_rd_en, weights_ready, done, err_cfg}, 0);
        exp_beats.delete(); exp_addrs.delete(); exp_kidx.delete();
        loading = 1'b0;
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        run_job(4, 'h200, 2, 0);

        for (int it = 0; it < 8; it++)
            run_job($urandom_range(1, 4), $urandom_range(0, 1023), $urandom_range(1, 3),
                    $urandom_range(0, 1));

        // Loader never starts: controller must keep waiting without fetching.
        rd_mode = 0; job_id++;
        cfg_k = 3'd2; cfg_base = AW'(0); cfg_n = CW'(1);
        r0 = rd_cnt;
        start = 1'b1; tick; start = 1'b0;
        repeat (100) tick;
        chk(busy, "busy_waiting", busy, 1);
        chk(rd_cnt == r0, "no_fetch_waiting", rd_cnt - r0, 0);
        rstn = 1'b0; tick; rstn = 1'b1; tick;
        chk(!busy, "busy_after_reset", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
